exec_pool_arbiter: RTL and testbench
====================================

Name: exec_pool_arbiter

Overview:
- Shares one issue stream from the decode/issue unit across p_num_units identical execution units, e.g. two iterative multipliers that serve the same op subset.
- Merges the units' results back into a single writeback stream.
- Round-robin on both sides; bounds total in-flight operations.
- Lets the DIU treat a pool of duplicated units as one pipe.

Parameters:
- p_num_units, 2, number of pooled execution units (2..8)
- p_seq_num_bits, 5, sequence-number width
- p_phys_addr_bits, 6, physical register address width
- p_max_inflight, 4, maximum dispatched-but-unreturned operations (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_val  in  1  issue request valid
- in_rdy  out  1  issue request ready
- in_seq_num  in  p_seq_num_bits  issue sequence number
- in_preg  in  p_phys_addr_bits  destination physical register
- in_op1  in  32  operand 1
- in_op2  in  32  operand 2
- unit_val  out  p_num_units  per-unit dispatch valid
- unit_rdy  in  p_num_units  per-unit dispatch ready
- unit_seq_num  out  p_seq_num_bits  broadcast payload
- unit_preg  out  p_phys_addr_bits  broadcast payload
- unit_op1  out  32  broadcast payload
- unit_op2  out  32  broadcast payload
- res_val  in  p_num_units  per-unit result valid
- res_rdy  out  p_num_units  per-unit result ready
- res_seq_num  in  p_num_units*p_seq_num_bits  packed; unit i at [i*W +: W]
- res_preg  in  p_num_units*p_phys_addr_bits  packed
- res_wdata  in  p_num_units*32  packed
- out_val  out  1  writeback valid
- out_rdy  in  1  writeback ready
- out_seq_num  out  p_seq_num_bits  writeback sequence number
- out_preg  out  p_phys_addr_bits  writeback register
- out_wdata  out  32  writeback data
- inflight  out  4  current in-flight count

Behaviour:
- Reset (async, rst=1): dispatch pointer=0, result pointer=0, out_val=0, out payload=0, inflight=0.
- Reset mid-operation discards the output register and counters immediately. Units are reset by the same rst.
- Handshake: a transfer occurs when val & rdy are high in the same cycle. val must not depend on rdy. A producer must hold payload while val & !rdy.
- Dispatch, combinational, zero latency:
  - Grant = first i with unit_rdy[i]=1, searching i = ptr, ptr+1, ... modulo p_num_units.
  - in_rdy = (|unit_rdy) & (inflight < p_max_inflight).
  - unit_val = onehot(grant) & {p_num_units{in_val & in_rdy}}. At most one bit is set.
  - Payload is broadcast unchanged to all units.
  - On dispatch fire, dispatch pointer <= grant+1, wrapping to 0 after p_num_units-1. No fire: pointer holds.
- Result merge, one-entry output register, latency 1:
  - Output register accepts when empty, or when draining this cycle (out_val & out_rdy).
  - When accepting, res_rdy = onehot(round-robin grant over res_val from result pointer). Otherwise res_rdy=0.
  - A result accepted in cycle N is presented on out_val/out_* in cycle N+1.
  - Sustained throughput is 1 result/cycle with out_rdy held high.
  - Result pointer <= granted index + 1 (mod p_num_units) on accept.
  - out_val clears on drain with no new accept. Payload holds while out_val & !out_rdy.
- Inflight counter:
  - +1 on dispatch fire; -1 on result accept (res_val & res_rdy, not output drain).
  - Simultaneous +1/-1: unchanged.
  - Saturation is prevented by in_rdy gating. Decrement at 0 is illegal; assert under simulation.
- Boundaries:
  - Full (inflight==p_max_inflight): in_rdy=0 even if units are ready. It rises in the cycle after a result accept.
  - All units busy: in_rdy=0 and the pointer holds.
  - Single ready unit: granted regardless of pointer.
  - Pointer wrap from p_num_units-1 goes to 0.
- Ordering: results may leave out of sequence order. The writeback/commit unit reorders by seq_num.

Optional Feature:
- Macro: EXEC_POOL_PERF_EN.
- When defined, add outputs:
  - perf_dispatch, 32 bits per unit, packed: dispatch fires per unit.
  - perf_full_stall, 32 bits: cycles with in_val & !in_rdy.
  - perf_wb_stall, 32 bits: cycles with out_val & !out_rdy.
- All counters reset to 0 and wrap at 2^32.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package exec_pool_pkg:
  - typedef exec_pool_req_t {seq_num, preg, op1, op2}
  - typedef exec_pool_res_t {seq_num, preg, wdata}
  - localparam for the inflight counter width
- Sub-module rr_arbiter, parameterised by width:
  - Inputs: req vector, ptr, fire.
  - Outputs: one-hot gnt, gnt_idx, next-ptr register.
  - Instantiated twice: dispatch and result.

Test Plan:
- Both units ready, 4 back-to-back requests, seq 0..3 -> unit_val sequence 01,10,01,10. Final inflight=4 and in_rdy=0 on the 5th cycle.
- unit_rdy=2'b10 only, ptr=0, request seq=7 -> unit_val=2'b10, dispatch pointer wraps to 0.
- res_val=2'b11 simultaneously with wdata 0x11 (unit0) and 0x22 (unit1), out_rdy=1 -> out_wdata 0x11 at N+1, 0x22 at N+2. inflight decreases by 2.
- out_rdy=0 for 3 cycles with one result held -> out_val stays 1, payload stable, res_rdy=0. Throughput returns to 1/cycle on release.
- Dispatch fire and result accept in the same cycle at inflight=2 -> inflight stays 2.
- Assert rst mid-stream with out_val=1, inflight=3 -> out_val=0, inflight=0, both pointers 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/exec_pool_pkg.sv
// rtl/exec_pool_pkg.sv - shared types and constants for the execution-pool arbiter
//
// Purpose: payload structs for the issue and writeback sides and the
// in-flight counter width. The struct field widths are the canonical
// seq-num / physical-register widths of this slice. exec_pool_arbiter's
// width parameters default to them and must be left equal to them.
package exec_pool_pkg;

  localparam int c_seq_num_bits   = 5;
  localparam int c_phys_addr_bits = 6;
  localparam int c_inflight_bits  = 4;

  typedef struct packed {
    logic [c_seq_num_bits-1:0]   seq_num;
    logic [c_phys_addr_bits-1:0] preg;
    logic [31:0]                 op1;
    logic [31:0]                 op2;
  } exec_pool_req_t;

  typedef struct packed {
    logic [c_seq_num_bits-1:0]   seq_num;
    logic [c_phys_addr_bits-1:0] preg;
    logic [31:0]                 wdata;
  } exec_pool_res_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with an internal priority pointer
//
// Purpose: grants the first requester at or after ptr (mod p_width). On fire,
// ptr moves to one past the granted index and wraps to 0 after p_width-1.
// Ports:
//   clk, rst  clock, async active-high reset (ptr <= 0)
//   req       request vector
//   fire      the current grant was consumed this cycle
//   gnt       one-hot grant (all zero when there is no request)
//   gnt_idx   binary index of gnt (0 when there is no request)
//   ptr       current priority pointer (registered)
module rr_arbiter #(
  parameter int p_width = 2,
  localparam int c_idx_bits = (p_width > 1) ? $clog2(p_width) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [p_width-1:0]    req,
  input  logic                  fire,
  output logic [p_width-1:0]    gnt,
  output logic [c_idx_bits-1:0] gnt_idx,
  output logic [c_idx_bits-1:0] ptr
);

  localparam logic [c_idx_bits-1:0] c_last = c_idx_bits'(p_width - 1);

  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    // Walk offsets from the pointer. The first hit wins, so the search
    // order itself gives the rotating priority.
    for (int off = 0; off < p_width; off++) begin
      idx = int'(ptr) + off;
      if (idx >= p_width) idx = idx - p_width;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx[c_idx_bits-1:0];
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (gnt_idx == c_last) ? '0 : gnt_idx + c_idx_bits'(1);
    end
  end

endmodule

// File: rtl/exec_pool_arbiter.sv
// rtl/exec_pool_arbiter.sv - shares one issue stream across a pool of units and merges results
//
// Purpose: dispatches each issue request to one execution unit, chosen
// round-robin among the ready units. The dispatch is zero-latency and the
// payload goes unchanged to every unit. Results are merged round-robin into
// a one-entry writeback register with latency 1. The number of
// dispatched-but-unreturned operations is capped at p_max_inflight.
// Optional feature: define EXEC_POOL_PERF_EN to add the perf counters.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_val/in_rdy, in_*            issue stream from decode/issue
//   unit_val/unit_rdy, unit_*      per-unit dispatch handshake, broadcast payload
//   res_val/res_rdy, res_*         per-unit result streams, packed per unit
//   out_val/out_rdy, out_*         merged writeback stream
//   inflight                       current in-flight count
//   perf_dispatch, perf_full_stall, perf_wb_stall   (EXEC_POOL_PERF_EN only)
module exec_pool_arbiter
  import exec_pool_pkg::*;
#(
  parameter int p_num_units      = 2,
  parameter int p_seq_num_bits   = c_seq_num_bits,
  parameter int p_phys_addr_bits = c_phys_addr_bits,
  parameter int p_max_inflight   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_val,
  output logic                                  in_rdy,
  input  logic [p_seq_num_bits-1:0]             in_seq_num,
  input  logic [p_phys_addr_bits-1:0]           in_preg,
  input  logic [31:0]                           in_op1,
  input  logic [31:0]                           in_op2,
  output logic [p_num_units-1:0]                unit_val,
  input  logic [p_num_units-1:0]                unit_rdy,
  output logic [p_seq_num_bits-1:0]             unit_seq_num,
  output logic [p_phys_addr_bits-1:0]           unit_preg,
  output logic [31:0]                           unit_op1,
  output logic [31:0]                           unit_op2,
  input  logic [p_num_units-1:0]                res_val,
  output logic [p_num_units-1:0]                res_rdy,
  input  logic [p_num_units*p_seq_num_bits-1:0] res_seq_num,
  input  logic [p_num_units*p_phys_addr_bits-1:0] res_preg,
  input  logic [p_num_units*32-1:0]             res_wdata,
  output logic                                  out_val,
  input  logic                                  out_rdy,
  output logic [p_seq_num_bits-1:0]             out_seq_num,
  output logic [p_phys_addr_bits-1:0]           out_preg,
  output logic [31:0]                           out_wdata,
  output logic [c_inflight_bits-1:0]            inflight
`ifdef EXEC_POOL_PERF_EN
  ,
  output logic [p_num_units*32-1:0]             perf_dispatch,
  output logic [31:0]                           perf_full_stall,
  output logic [31:0]                           perf_wb_stall
`endif
);

  localparam int c_idx_bits = (p_num_units > 1) ? $clog2(p_num_units) : 1;

  logic [p_num_units-1:0] disp_gnt;
  logic [c_idx_bits-1:0]  disp_idx;
  logic [c_idx_bits-1:0]  disp_ptr;
  logic                   disp_fire;

  logic [p_num_units-1:0] res_req;
  logic [p_num_units-1:0] res_gnt;
  logic [c_idx_bits-1:0]  res_idx;
  logic [c_idx_bits-1:0]  res_ptr;
  logic                   res_fire;
  logic                   out_accept;

  exec_pool_res_t         out_q;

  // Dispatch side. in_rdy looks only at unit readiness and the in-flight
  // cap, never at in_val, so the issue handshake has no val->rdy path.
  assign in_rdy    = (|unit_rdy) && (inflight < c_inflight_bits'(p_max_inflight));
  assign disp_fire = in_val && in_rdy;
  assign unit_val  = disp_gnt & {p_num_units{disp_fire}};

  assign unit_seq_num = in_seq_num;
  assign unit_preg    = in_preg;
  assign unit_op1     = in_op1;
  assign unit_op2     = in_op2;

  rr_arbiter #(.p_width(p_num_units)) u_disp_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (unit_rdy),
    .fire    (disp_fire),
    .gnt     (disp_gnt),
    .gnt_idx (disp_idx),
    .ptr     (disp_ptr)
  );

  // Result side. The register can take a new result when it is empty or
  // when it drains this cycle, so back-to-back results keep 1/cycle.
  assign out_accept = !out_val || out_rdy;
  assign res_req    = res_val & {p_num_units{out_accept}};
  assign res_rdy    = res_gnt;
  assign res_fire   = |(res_val & res_rdy);

  rr_arbiter #(.p_width(p_num_units)) u_res_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (res_req),
    .fire    (res_fire),
    .gnt     (res_gnt),
    .gnt_idx (res_idx),
    .ptr     (res_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val <= 1'b0;
      out_q   <= '0;
    end else if (res_fire) begin
      out_val       <= 1'b1;
      out_q.seq_num <= res_seq_num[res_idx*p_seq_num_bits +: p_seq_num_bits];
      out_q.preg    <= res_preg[res_idx*p_phys_addr_bits +: p_phys_addr_bits];
      out_q.wdata   <= res_wdata[res_idx*32 +: 32];
    end else if (out_rdy) begin
      out_val <= 1'b0;
    end
  end

  assign out_seq_num = out_q.seq_num;
  assign out_preg    = out_q.preg;
  assign out_wdata   = out_q.wdata;

  // The count goes down when a unit hands back a result, not when that
  // result drains from the writeback register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({disp_fire, res_fire})
        2'b10:   inflight <= inflight + c_inflight_bits'(1);
        2'b01:   inflight <= inflight - c_inflight_bits'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  inflight_underflow : assert property (@(posedge clk) disable iff (rst)
    !(res_fire && !disp_fire && (inflight == '0)));

`ifdef EXEC_POOL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dispatch   <= '0;
      perf_full_stall <= '0;
      perf_wb_stall   <= '0;
    end else begin
      for (int i = 0; i < p_num_units; i++) begin
        if (unit_val[i]) perf_dispatch[i*32 +: 32] <= perf_dispatch[i*32 +: 32] + 32'd1;
      end
      if (in_val && !in_rdy)   perf_full_stall <= perf_full_stall + 32'd1;
      if (out_val && !out_rdy) perf_wb_stall   <= perf_wb_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_pool_arbiter.sv
// tb/tb_exec_pool_arbiter.sv - directed self-checking bench for exec_pool_arbiter
module tb_exec_pool_arbiter;

  localparam int NU = 2;
  localparam int SW = 5;
  localparam int PW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_val;
  logic           in_rdy;
  logic [SW-1:0]  in_seq_num;
  logic [PW-1:0]  in_preg;
  logic [31:0]    in_op1;
  logic [31:0]    in_op2;
  logic [NU-1:0]  unit_val;
  logic [NU-1:0]  unit_rdy;
  logic [SW-1:0]  unit_seq_num;
  logic [PW-1:0]  unit_preg;
  logic [31:0]    unit_op1;
  logic [31:0]    unit_op2;
  logic [NU-1:0]  res_val;
  logic [NU-1:0]  res_rdy;
  logic [NU*SW-1:0] res_seq_num;
  logic [NU*PW-1:0] res_preg;
  logic [NU*32-1:0] res_wdata;
  logic           out_val;
  logic           out_rdy;
  logic [SW-1:0]  out_seq_num;
  logic [PW-1:0]  out_preg;
  logic [31:0]    out_wdata;
  logic [3:0]     inflight;
`ifdef EXEC_POOL_PERF_EN
  logic [NU*32-1:0] perf_dispatch;
  logic [31:0]    perf_full_stall;
  logic [31:0]    perf_wb_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_pool_arbiter #(
    .p_num_units(NU), .p_seq_num_bits(SW), .p_phys_addr_bits(PW), .p_max_inflight(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_seq_num(in_seq_num), .in_preg(in_preg),
    .in_op1(in_op1), .in_op2(in_op2),
    .unit_val(unit_val), .unit_rdy(unit_rdy), .unit_seq_num(unit_seq_num),
    .unit_preg(unit_preg), .unit_op1(unit_op1), .unit_op2(unit_op2),
    .res_val(res_val), .res_rdy(res_rdy), .res_seq_num(res_seq_num),
    .res_preg(res_preg), .res_wdata(res_wdata),
    .out_val(out_val), .out_rdy(out_rdy), .out_seq_num(out_seq_num),
    .out_preg(out_preg), .out_wdata(out_wdata), .inflight(inflight)
`ifdef EXEC_POOL_PERF_EN
    , .perf_dispatch(perf_dispatch), .perf_full_stall(perf_full_stall),
    .perf_wb_stall(perf_wb_stall)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input int u, input int seq, input int preg, input logic [31:0] wdata);
    res_seq_num[u*SW +: SW] = SW'(seq);
    res_preg[u*PW +: PW]    = PW'(preg);
    res_wdata[u*32 +: 32]   = wdata;
  endtask

  initial begin
    rst = 1'b1;
    in_val = 1'b0; in_seq_num = '0; in_preg = '0; in_op1 = '0; in_op2 = '0;
    unit_rdy = '0; res_val = '0; res_seq_num = '0; res_preg = '0; res_wdata = '0;
    out_rdy = 1'b0;
    #2;
    check("rst_out_val", 64'(out_val), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_out_wdata", 64'(out_wdata), 64'd0);
    check("rst_in_rdy_no_units", 64'(in_rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Four back-to-back requests alternate between the two units, then full.
    unit_rdy = 2'b11; in_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_seq_num = SW'(i); in_preg = PW'(i + 10); in_op1 = 32'(i * 3); in_op2 = 32'hA5;
      #1;
      check("b2b_unit_val", 64'(unit_val), (i % 2 == 0) ? 64'd1 : 64'd2);
      check("b2b_in_rdy", 64'(in_rdy), 64'd1);
      check("b2b_bcast_seq", 64'(unit_seq_num), 64'(i));
      step();
    end
    #1;
    check("full_inflight", 64'(inflight), 64'd4);
    check("full_in_rdy", 64'(in_rdy), 64'd0);
    check("full_unit_val", 64'(unit_val), 64'd0);
    in_val = 1'b0;

    // Simultaneous results from both units drain one per cycle.
    set_res(0, 0, 1, 32'h11); set_res(1, 1, 2, 32'h22);
    res_val = 2'b11; out_rdy = 1'b1;
    #1;
    check("dual_res_rdy0", 64'(res_rdy), 64'd1);
    check("dual_in_rdy_full", 64'(in_rdy), 64'd0);
    step();
    res_val = 2'b10;
    #1;
    check("dual_out_val1", 64'(out_val), 64'd1);
    check("dual_out_wdata1", 64'(out_wdata), 64'h11);
    check("dual_out_preg1", 64'(out_preg), 64'd1);
    check("dual_inflight1", 64'(inflight), 64'd3);
    check("dual_in_rdy_rise", 64'(in_rdy), 64'd1);
    check("dual_res_rdy1", 64'(res_rdy), 64'd2);
    step();
    res_val = 2'b00;
    #1;
    check("dual_out_wdata2", 64'(out_wdata), 64'h22);
    check("dual_out_seq2", 64'(out_seq_num), 64'd1);
    check("dual_inflight2", 64'(inflight), 64'd2);
    step();
    #1;
    check("dual_drained", 64'(out_val), 64'd0);

    // Only unit 1 ready with pointer at 0: unit 1 granted, pointer wraps.
    unit_rdy = 2'b10; in_val = 1'b1; in_seq_num = 5'd7;
    #1;
    check("single_unit_val", 64'(unit_val), 64'd2);
    check("single_bcast_seq", 64'(unit_seq_num), 64'd7);
    step();
    in_val = 1'b0; unit_rdy = 2'b11;
    set_res(0, 2, 3, 32'h33); res_val = 2'b01;
    #1;
    check("single_inflight", 64'(inflight), 64'd3);
    check("ret_res_rdy", 64'(res_rdy), 64'd1);
    step();

    // Dispatch fire and result accept together at inflight=2.
    res_val = 2'b10; set_res(1, 3, 4, 32'h44);
    in_val = 1'b1; in_seq_num = 5'd8;
    #1;
    check("sim_inflight_pre", 64'(inflight), 64'd2);
    check("wrap_unit_val", 64'(unit_val), 64'd1);
    check("sim_res_rdy", 64'(res_rdy), 64'd2);
    check("sim_out_wdata_pre", 64'(out_wdata), 64'h33);
    step();
    in_val = 1'b0; res_val = 2'b00;
    #1;
    check("sim_inflight_post", 64'(inflight), 64'd2);
    check("sim_out_wdata_post", 64'(out_wdata), 64'h44);

    // Writeback backpressure for three cycles with a result waiting.
    out_rdy = 1'b0; set_res(0, 9, 5, 32'h55); res_val = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_out_val", 64'(out_val), 64'd1);
      check("bp_out_wdata", 64'(out_wdata), 64'h44);
      check("bp_res_rdy", 64'(res_rdy), 64'd0);
      step();
    end
    out_rdy = 1'b1;
    #1;
    check("rel_res_rdy0", 64'(res_rdy), 64'd1);
    step();
    res_val = 2'b10; set_res(1, 10, 6, 32'h66);
    #1;
    check("rel_out_wdata0", 64'(out_wdata), 64'h55);
    check("rel_res_rdy1", 64'(res_rdy), 64'd2);
    step();
    res_val = 2'b00;
    #1;
    check("rel_out_wdata1", 64'(out_wdata), 64'h66);
    check("rel_out_seq1", 64'(out_seq_num), 64'd10);
    check("rel_inflight", 64'(inflight), 64'd0);
    step();
    #1;
    check("rel_drained", 64'(out_val), 64'd0);

    // Fill to 4 from pointer 1, accept one result held under backpressure.
    in_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_seq_num = SW'(i + 16);
      #1;
      check("fill_unit_val", 64'(unit_val), (i % 2 == 0) ? 64'd2 : 64'd1);
      step();
    end
    in_val = 1'b0; out_rdy = 1'b0;
    set_res(0, 16, 7, 32'h77); res_val = 2'b01;
    #1;
    check("pre_rst_res_rdy", 64'(res_rdy), 64'd1);
    step();
    res_val = 2'b00;
    #1;
    check("pre_rst_out_val", 64'(out_val), 64'd1);
    check("pre_rst_inflight", 64'(inflight), 64'd3);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_val", 64'(out_val), 64'd0);
    check("async_rst_inflight", 64'(inflight), 64'd0);
    check("async_rst_out_wdata", 64'(out_wdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_val = 1'b1; unit_rdy = 2'b11; res_val = 2'b11; out_rdy = 1'b1;
    #1;
    check("post_rst_disp_ptr", 64'(unit_val), 64'd1);
    check("post_rst_res_ptr", 64'(res_rdy), 64'd1);
    step();
    in_val = 1'b0; res_val = 2'b00;
    #1;
    check("post_rst_inflight", 64'(inflight), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
